accumulator_buffer: RTL and testbench
=====================================

// Module: accumulator_buffer
// PURPOSE
//  Row-buffered partial-sum accumulator between the systolic array and the quantizer array.
//  - Fill: accumulates one ARRAY_SIZE-wide row of partial sums per beat into a DEPTH-row bank,
//    over successive K-tile passes.
//  - Drain: after the final pass, presents the rows one at a time, over valid/ready, as the
//    ACCUMULATOR_DATA_WIDTH-wide ins[] vector of the quantizer array.
// PARAMETERS
//  ARRAY_SIZE              4                    columns per row; equals QUANTIZER_SIZE downstream
//  DEPTH                   4                    rows held per output tile
//  DEPTH_WIDTH             $clog2(DEPTH)        row pointer width
//  ACCUMULATOR_DATA_WIDTH  16                   signed width of partial sums and accumulators
// PORTS
//  clk        in   1                         single clock, rising edge
//  rst        in   1                         asynchronous, active-high reset
//  in_valid   in   1                         psums row valid
//  in_ready   out  1                         buffer accepts a row (high only in FILL)
//  in_first   in   1                         pass is first K-tile: overwrite instead of add
//  in_last    in   1                         pass is last K-tile: drain after this pass
//  psums      in   ACC_W x ARRAY_SIZE        signed partial-sum row from the systolic array
//  out_valid  out  1                         out_data row valid
//  out_ready  in   1                         quantizer side consumes the row
//  out_data   out  ACC_W x ARRAY_SIZE        accumulated row, feeds quantizer_array ins[]
//  out_row    out  DEPTH_WIDTH               index of the row on out_data
//  busy       out  1                         high in DRAIN, or in FILL with wp != 0
// BEHAVIOUR
//  Reset: all bank entries 0, wp = 0, rp = 0, state FILL, first_q = 0, last_q = 0.
//    Outputs: in_ready = 1, out_valid = 0, out_row = 0, out_data = 0, busy = 0.
//  Reset mid-operation discards all rows and pass flags; no partial drain resumes.
//  FILL state:
//    - in_ready = 1, out_valid = 0.
//    - Beat = in_valid & in_ready; it writes row wp and then increments wp.
//    - wp wraps from DEPTH-1 to 0.
//    - At wp == 0, the beat's in_first/in_last are latched into first_q/last_q for the pass.
//    - At wp != 0, in_first/in_last are ignored and the latched values are used.
//  Write rule, per column c:
//    - first: bank[wp][c] <= psums[c].
//    - otherwise: bank[wp][c] <= sat(bank[wp][c] + psums[c]).
//  sat(): sign-extend both operands to ACC_W+1 bits and add.
//    Clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1], i.e. [-32768, 32767] at the default width.
//  Pass end: a beat at wp == DEPTH-1 with last set (latched) moves to DRAIN on the next edge.
//    Without last set, the state stays FILL and the next pass begins at wp = 0.
//  DRAIN state:
//    - in_ready = 0; in_valid is ignored.
//    - out_valid = 1, out_data = bank[rp], out_row = rp.
//    - out_data and out_row are held stable until the handshake (out_valid & out_ready).
//    - Handshake: rp increments. At rp == DEPTH-1, rp -> 0 and the state returns to FILL.
//  Latency:
//    - The last-pass beat accepted at edge N gives out_valid = 1 in cycle N+1.
//    - Minimum drain is DEPTH cycles with out_ready tied high.
//    - The first FILL beat of the next tile can be accepted the cycle after the final handshake.
//  Boundary conditions:
//    - out_ready held low: rows hold indefinitely, with no drop and no overwrite.
//    - in_valid while in DRAIN: no write and no pointer movement.
//    - in_first and in_last set on the same pass: single-pass tile (overwrite, then drain).
//    - Saturation is sticky per pass: a clamped value is the operand for the next pass's add.
//  Storage: registers only, no inferred RAM. out_data is a combinational mux of bank[rp].
// STRUCTURE
//  Shared package tpu_pkg:
//    - ACCUMULATOR_DATA_WIDTH and COMPUTE_DATA_WIDTH constants.
//    - typedef acc_t (signed logic [ACC_W-1:0]).
//    - typedef enum {FILL, DRAIN} acc_buf_state_e.
//  Sub-module sat_adder, instanced ARRAY_SIZE times:
//    - combinational signed a + b with clamp;
//    - parameter ACCUMULATOR_DATA_WIDTH.
//  Top level holds the FSM, the pointers, the pass-flag latches and the bank.
// TESTING
//  1. Single pass: first = last = 1; rows r hold psums {r, -r, 100, -100}.
//     -> 4 drain beats, out_row 0..3, identical values, out_valid in the cycle after the 4th beat.
//  2. Three passes (first on pass 1, last on pass 3), each psum = 1000.
//     -> every out_data lane = 3000; in_ready = 0 throughout the drain.
//  3. Saturation: pass 1 = 30000, pass 2 = 5000 -> 32767.
//     Pass 1 = -30000, pass 2 = -5000 -> -32768.
//     Pass 3 adds -1 to the clamped 32767 -> 32766.
//  4. Backpressure: out_ready low 10 cycles, then toggled every other cycle.
//     -> each row appears exactly once, in order 0..3, data stable while stalled.
//     in_valid = 1 during the drain causes no writes.
//  5. Flag latching: in_first = 1 only on row 0 of pass 2, and in_last toggled on rows 1-3.
//     -> pass 2 overwrites all 4 rows; the drain follows only a pass whose row-0 beat had last = 1.
//  6. Reset: assert rst mid-drain at rp = 2.
//     -> out_valid = 0 immediately, in_ready = 1, bank = 0.
//     A new single pass of 7s drains as 7, not summed with the old data.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU datapath constants and types used by the accumulator buffer and its neighbours.
package tpu_pkg;

  localparam int ACCUMULATOR_DATA_WIDTH = 16;
  localparam int COMPUTE_DATA_WIDTH     = 8;

  typedef logic signed [ACCUMULATOR_DATA_WIDTH-1:0] acc_t;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } acc_buf_state_e;

endpackage

// File: rtl/sat_adder.sv
// Combinational signed add that clamps to the representable range instead of wrapping.
module sat_adder #(
  parameter int ACCUMULATOR_DATA_WIDTH = 16
) (
  input  logic signed [ACCUMULATOR_DATA_WIDTH-1:0] a,
  input  logic signed [ACCUMULATOR_DATA_WIDTH-1:0] b,
  output logic signed [ACCUMULATOR_DATA_WIDTH-1:0] sum
);

  localparam int W = ACCUMULATOR_DATA_WIDTH;

  logic signed [W:0] wide_sum;

  always_comb begin
    wide_sum = {a[W-1], a} + {b[W-1], b};
    // The two top bits disagree only when the true sum left the W-bit range.
    if (wide_sum[W] != wide_sum[W-1]) begin
      sum = wide_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sum = wide_sum[W-1:0];
    end
  end

endmodule

// File: rtl/accumulator_buffer.sv
// Row bank that accumulates K-tile partial sums (FILL) and then streams finished rows
// to the quantizer array (DRAIN).
module accumulator_buffer #(
  parameter int ARRAY_SIZE             = 4,
  parameter int DEPTH                  = 4,
  parameter int DEPTH_WIDTH            = $clog2(DEPTH),
  parameter int ACCUMULATOR_DATA_WIDTH = tpu_pkg::ACCUMULATOR_DATA_WIDTH
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  input  logic                                               in_first,
  input  logic                                               in_last,
  input  logic [ARRAY_SIZE-1:0][ACCUMULATOR_DATA_WIDTH-1:0] psums,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [ARRAY_SIZE-1:0][ACCUMULATOR_DATA_WIDTH-1:0] out_data,
  output logic [DEPTH_WIDTH-1:0]                             out_row,
  output logic                                               busy
);

  import tpu_pkg::*;

  localparam int W = ACCUMULATOR_DATA_WIDTH;
  localparam logic [DEPTH_WIDTH-1:0] LAST_ROW = DEPTH_WIDTH'(DEPTH - 1);

  typedef logic [ARRAY_SIZE-1:0][W-1:0] row_t;

  acc_buf_state_e         state_q, state_d;
  logic [DEPTH_WIDTH-1:0] wp_q, wp_d;
  logic [DEPTH_WIDTH-1:0] rp_q, rp_d;
  logic                   first_q, first_d;
  logic                   last_q, last_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  row_t                   bank_q [DEPTH];
  row_t                   bank_d [DEPTH];

  row_t                   cur_row;
  logic [W-1:0]           sum_lane [ARRAY_SIZE];
  logic                   beat;
  logic                   drain_hs;
  logic                   pass_first;
  logic                   pass_last;

  assign cur_row = bank_q[wp_q];

  for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_lane
    sat_adder #(.ACCUMULATOR_DATA_WIDTH(W)) u_sat (
      .a   (cur_row[c]),
      .b   (psums[c]),
      .sum (sum_lane[c])
    );
  end

  // Both ports transfer on a cycle where valid and ready are high at the rising edge;
  // valid never depends on ready, and out_data/out_row hold until that transfer.
  always_comb begin
    beat        = in_valid & in_ready_q;
    drain_hs    = out_valid_q & out_ready;
    pass_first  = (wp_q == '0) ? in_first : first_q;
    pass_last   = (wp_q == '0) ? in_last  : last_q;
    state_d     = state_q;
    wp_d        = wp_q;
    rp_d        = rp_q;
    first_d     = first_q;
    last_d      = last_q;
    bank_d      = bank_q;

    if (beat) begin
      for (int c = 0; c < ARRAY_SIZE; c++) begin
        bank_d[wp_q][c] = pass_first ? psums[c] : sum_lane[c];
      end
      wp_d = (wp_q == LAST_ROW) ? '0 : wp_q + DEPTH_WIDTH'(1);
      if (wp_q == '0) begin
        first_d = in_first;
        last_d  = in_last;
      end
      if ((wp_q == LAST_ROW) && pass_last) begin
        state_d = DRAIN;
      end
    end

    if (drain_hs) begin
      rp_d = (rp_q == LAST_ROW) ? '0 : rp_q + DEPTH_WIDTH'(1);
      if (rp_q == LAST_ROW) begin
        state_d = FILL;
      end
    end

    in_ready_d  = (state_d == FILL);
    out_valid_d = (state_d == DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      wp_q        <= '0;
      rp_q        <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      first_q     <= first_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      bank_q      <= bank_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = bank_q[rp_q];
  assign out_row   = rp_q;
  assign busy      = (state_q == DRAIN) | (wp_q != '0);

endmodule

// File: tb/tb_accumulator_buffer.sv
// Bench for accumulator_buffer: directed tile scenarios plus random tiles against a pass-level model.
module tb_accumulator_buffer;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int W  = 16;
  localparam int LW = N * W;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_first;
  logic                  in_last;
  logic [N-1:0][W-1:0]   psums;
  logic                  out_valid;
  logic                  out_ready;
  logic [N-1:0][W-1:0]   out_data;
  logic [1:0]            out_row;
  logic                  busy;

  int n_vec = 0;
  int n_err = 0;

  logic [LW-1:0] exp_q[$];
  int            exp_row_q[$];
  int            mb [D][N];

  bit fr [D];
  bit lr [D];
  int dat [D][N];

  accumulator_buffer #(
    .ARRAY_SIZE(N), .DEPTH(D), .DEPTH_WIDTH(2), .ACCUMULATOR_DATA_WIDTH(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_last   (in_last),
    .psums     (psums),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .busy      (busy)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model helpers
  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [LW-1:0] pack_row(input int r);
    logic [LW-1:0] p;
    p = '0;
    for (int c = 0; c < N; c++) p[c*W +: W] = W'(mb[r][c]);
    return p;
  endfunction

  function automatic int rnd_val();
    logic signed [W-1:0] v;
    v = W'($urandom_range(0, 65535));
    return int'(v);
  endfunction

  task automatic set_flags(input bit f, input bit l);
    for (int r = 0; r < D; r++) begin
      fr[r] = f;
      lr[r] = l;
    end
  endtask

  task automatic set_const(input int v);
    for (int r = 0; r < D; r++)
      for (int c = 0; c < N; c++) dat[r][c] = v;
  endtask

  task automatic set_random();
    for (int r = 0; r < D; r++)
      for (int c = 0; c < N; c++) dat[r][c] = rnd_val();
  endtask

  // Driver: one pass of D rows; only row 0's flags define the pass.
  task automatic send_pass(input bit f_r[D], input bit l_r[D], input int d_r[D][N]);
    bit f;
    bit l;
    int w;
    f = f_r[0];
    l = l_r[0];
    for (int r = 0; r < D; r++) begin
      in_valid = 1'b1;
      in_first = f_r[r];
      in_last  = l_r[r];
      for (int c = 0; c < N; c++) psums[c] = W'(d_r[r][c]);
      w = 0;
      while (!in_ready && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      if (!in_ready) check_eq("in_ready_wait", {63'd0, in_ready}, 1);
      @(posedge clk); #1;
      for (int c = 0; c < N; c++)
        mb[r][c] = f ? d_r[r][c] : sat16(mb[r][c] + d_r[r][c]);
      if (r == 1) check_eq("busy_fill", {63'd0, busy}, 1);
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    if (l) begin
      for (int r = 0; r < D; r++) begin
        exp_q.push_back(pack_row(r));
        exp_row_q.push_back(r);
      end
    end
  endtask

  // Drain with a chosen out_ready pattern; mode 0 = always ready, 1 = stall then toggle, 2 = random.
  task automatic drain_tile(input int mode, input bit junk, input int nrows, input string tag);
    int            got;
    int            cyc;
    bit            stalled;
    logic [LW-1:0] held_d;
    logic [1:0]    held_r;
    logic [LW-1:0] e;
    int            er;
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    held_d = '0;
    held_r = '0;
    while (got < nrows && cyc < 300) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc >= 10) && cyc[0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (junk && got < D - 1) begin
        in_valid = 1'b1;
        in_first = 1'($urandom_range(0, 1));
        in_last  = 1'($urandom_range(0, 1));
        for (int c = 0; c < N; c++) psums[c] = W'($urandom_range(0, 65535));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc == 0) begin
        check_eq({tag, "_latency"}, {63'd0, out_valid}, 1);
        check_eq({tag, "_busy_drain"}, {63'd0, busy}, 1);
      end
      check_eq({tag, "_in_ready_low"}, {63'd0, in_ready}, 0);
      if (stalled) begin
        check_eq({tag, "_hold_data"}, out_data, held_d);
        check_eq({tag, "_hold_row"}, {62'd0, out_row}, {62'd0, held_r});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq({tag, "_unexpected_row"}, out_data, '0);
        end else begin
          e  = exp_q.pop_front();
          er = exp_row_q.pop_front();
          check_eq({tag, "_data"}, out_data, e);
          check_eq({tag, "_row"}, {62'd0, out_row}, LW'(er));
        end
        got++;
        stalled = 1'b0;
      end else begin
        stalled = out_valid;
        held_d  = out_data;
        held_r  = out_row;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    check_eq({tag, "_rows_drained"}, LW'(got), LW'(nrows));
    if (mode == 0 && nrows == D) check_eq({tag, "_drain_cycles"}, LW'(cyc), LW'(D));
    if (nrows == D) begin
      check_eq({tag, "_refill_ready"}, {63'd0, in_ready}, 1);
      check_eq({tag, "_refill_valid"}, {63'd0, out_valid}, 0);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_in_ready"}, {63'd0, in_ready}, 1);
    check_eq({tag, "_out_valid"}, {63'd0, out_valid}, 0);
    check_eq({tag, "_out_row"}, {62'd0, out_row}, 0);
    check_eq({tag, "_out_data"}, out_data, '0);
    check_eq({tag, "_busy"}, {63'd0, busy}, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    psums     = '0;
    for (int r = 0; r < D; r++)
      for (int c = 0; c < N; c++) mb[r][c] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;

    // Single-pass tile
    set_flags(1, 1);
    for (int r = 0; r < D; r++) begin
      dat[r][0] = r;
      dat[r][1] = -r;
      dat[r][2] = 100;
      dat[r][3] = -100;
    end
    send_pass(fr, lr, dat);
    drain_tile(0, 0, D, "single");

    // Three passes of 1000
    set_const(1000);
    set_flags(1, 0);
    send_pass(fr, lr, dat);
    set_flags(0, 0);
    send_pass(fr, lr, dat);
    set_flags(0, 1);
    send_pass(fr, lr, dat);
    drain_tile(0, 0, D, "three_pass");

    // Saturation, sticky across the following pass
    for (int r = 0; r < D; r++)
      for (int c = 0; c < N; c++) dat[r][c] = (c % 2 == 0) ? 30000 : -30000;
    set_flags(1, 0);
    send_pass(fr, lr, dat);
    for (int r = 0; r < D; r++)
      for (int c = 0; c < N; c++) dat[r][c] = (c % 2 == 0) ? 5000 : -5000;
    set_flags(0, 1);
    send_pass(fr, lr, dat);
    drain_tile(0, 0, D, "sat_clamp");
    for (int r = 0; r < D; r++)
      for (int c = 0; c < N; c++) dat[r][c] = (c % 2 == 0) ? -1 : 1;
    send_pass(fr, lr, dat);
    drain_tile(0, 0, D, "sat_sticky");

    // Backpressure with in_valid noise, then an accumulate pass exposes any stray write
    set_random();
    set_flags(1, 1);
    send_pass(fr, lr, dat);
    drain_tile(1, 1, D, "backpressure");
    for (int r = 0; r < D; r++)
      for (int c = 0; c < N; c++) dat[r][c] = int'($urandom_range(0, 200)) - 100;
    set_flags(0, 1);
    send_pass(fr, lr, dat);
    drain_tile(0, 0, D, "no_stray_write");

    // Flag latching: only row 0 flags matter
    set_random();
    set_flags(1, 0);
    send_pass(fr, lr, dat);
    set_random();
    fr = '{1, 0, 0, 0};
    lr = '{0, 1, 0, 1};
    send_pass(fr, lr, dat);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("flags_no_drain_valid", {63'd0, out_valid}, 0);
    check_eq("flags_no_drain_ready", {63'd0, in_ready}, 1);
    @(posedge clk); #1;
    set_random();
    fr = '{0, 1, 1, 1};
    lr = '{1, 0, 0, 0};
    send_pass(fr, lr, dat);
    drain_tile(2, 0, D, "flags");

    // Reset in the middle of a drain
    set_random();
    set_flags(1, 1);
    send_pass(fr, lr, dat);
    drain_tile(0, 0, 2, "pre_reset");
    check_eq("pre_reset_row", {62'd0, out_row}, 2);
    #2 rst = 1'b1;
    #1;
    check_idle("mid_drain_reset");
    exp_q.delete();
    exp_row_q.delete();
    for (int r = 0; r < D; r++)
      for (int c = 0; c < N; c++) mb[r][c] = 0;
    @(posedge clk); #1 rst = 1'b0;
    set_const(7);
    set_flags(0, 1);
    send_pass(fr, lr, dat);
    drain_tile(0, 0, D, "after_reset");

    // Random tiles with random backpressure
    for (int t = 0; t < 6; t++) begin
      int np;
      np = int'($urandom_range(1, 3));
      for (int p = 0; p < np; p++) begin
        set_random();
        set_flags(p == 0, p == np - 1);
        send_pass(fr, lr, dat);
      end
      drain_tile(2, 1, D, "random");
    end

    check_eq("queue_empty", LW'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
